// File: rtl/matrix_stream_sequencer_pkg.sv
// Shared types and helpers for the matrix stream sequencer.
// Covers the order-select constants, the FSM state enum and element bit offsets.
package matrix_stream_sequencer_pkg;

  localparam logic ROW_MAJOR = 1'b0;
  localparam logic COL_MAJOR = 1'b1;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  // Bit offset of element (row, col) inside a flattened row-major matrix.
  function automatic int unsigned elem_offset(input int unsigned row, input int unsigned col,
                                              input int unsigned dim,
                                              input int unsigned data_w);
    return (row * dim + col) * data_w;
  endfunction

endpackage

// File: rtl/matrix_element_mux.sv
// Combinational selector of element (row, col) from a flattened DIM x DIM matrix.
module matrix_element_mux
  import matrix_stream_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM    = 4,
  localparam int unsigned IDX_W = $clog2(DIM)
) (
  input  logic [DIM*DIM*DATA_W-1:0] mat,
  input  logic [IDX_W-1:0]          row,
  input  logic [IDX_W-1:0]          col,
  output logic [DATA_W-1:0]         data
);

  // Constant part-selects only; indices outside DIM x DIM select zero.
  always_comb begin
    data = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      for (int unsigned c = 0; c < DIM; c++) begin
        if (row == IDX_W'(r) && col == IDX_W'(c)) begin
          data = mat[elem_offset(r, c, DIM, DATA_W) +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/matrix_stream_sequencer.sv
// Snapshots a DIM x DIM matrix on start and streams its elements over a valid/ready
// handshake in row-major or column-major (transposed) order.
module matrix_stream_sequencer
  import matrix_stream_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIM    = 4,
  localparam int unsigned IDX_W = $clog2(DIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIM*DIM*DATA_W-1:0] mat_in,
  input  logic                      start,
  input  logic                      col_major,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_row,
  output logic [IDX_W-1:0]          out_col,
  output logic                      out_last,
  output logic                      done
);

  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] OneIdx = IDX_W'(1);

  state_e                    state_q;
  logic [DIM*DIM*DATA_W-1:0] snap_q;
  logic                      mode_q;
  logic [IDX_W-1:0]          row_q, col_q;
  logic [IDX_W-1:0]          row_d, col_d;
  logic                      valid_q, last_q, done_q;

  // Successor indices; wrap is explicit at DIM-1 so non-power-of-two DIM works.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (mode_q == COL_MAJOR) begin
      if (row_q == MaxIdx) begin
        row_d = '0;
        col_d = col_q + OneIdx;
      end else begin
        row_d = row_q + OneIdx;
      end
    end else begin
      if (col_q == MaxIdx) begin
        col_d = '0;
        row_d = row_q + OneIdx;
      end else begin
        col_d = col_q + OneIdx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      snap_q  <= '0;
      mode_q  <= ROW_MAJOR;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StStream;
            snap_q  <= mat_in;
            mode_q  <= col_major;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        StStream: begin
          done_q <= 1'b0;
          if (out_ready) begin
            if (last_q) begin
              state_q <= StIdle;
              row_q   <= '0;
              col_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q  <= row_d;
              col_q  <= col_d;
              last_q <= (row_d == MaxIdx) && (col_d == MaxIdx);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = valid_q;
  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign done      = done_q;

  matrix_element_mux #(
    .DATA_W(DATA_W),
    .DIM   (DIM)
  ) u_mux (
    .mat (snap_q),
    .row (row_q),
    .col (col_q),
    .data(out_data)
  );

endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Self-checking bench: DIM=4/8-bit instance against a queue-based order model,
// plus a DIM=3/16-bit instance for wrap and back-to-back start behaviour.
module tb_matrix_stream_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] mat_in;
  logic         start, col_major, out_ready;
  logic         busy, out_valid, out_last, done;
  logic [7:0]   out_data;
  logic [1:0]   out_row, out_col;

  logic [143:0] mat_in3;
  logic         start3, col_major3, out_ready3;
  logic         busy3, out_valid3, out_last3, done3;
  logic [15:0]  out_data3;
  logic [1:0]   out_row3, out_col3;

  matrix_stream_sequencer #(.DATA_W(8), .DIM(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mat_in(mat_in), .start(start), .col_major(col_major),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
  );

  matrix_stream_sequencer #(.DATA_W(16), .DIM(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mat_in(mat_in3), .start(start3), .col_major(col_major3),
    .busy(busy3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_row(out_row3), .out_col(out_col3), .out_last(out_last3), .done(done3)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] obs[16];
  logic [7:0] obs_rm[16];
  logic [7:0] obs_cm[16];
  logic [127:0] mat_dir;

  typedef struct {
    bit         cm;
    int         k;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected order is plain index arithmetic over the element number k.
  task automatic run_stream(input logic [127:0] mat, input logic cm, input int rmode,
                            input bit disturb);
    logic [7:0] qd[$];
    logic [1:0] qr[$];
    logic [1:0] qc[$];
    int guard;
    int k;
    guard = 0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      int r;
      int c;
      r = cm ? i % 4 : i / 4;
      c = cm ? i / 4 : i % 4;
      qd.push_back(mat[(r * 4 + c) * 8 +: 8]);
      qr.push_back(2'(r));
      qc.push_back(2'(c));
    end
    @(negedge clk);
    mat_in = mat;
    col_major = cm;
    start = 1'b1;
    out_ready = 1'b0;
    while (qd.size() > 0 && guard < 400) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (disturb && guard == 3) begin
        start = 1'b1;
        mat_in = '1;
        col_major = ~cm;
      end
      chk("valid", 32'(out_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("data", 32'(out_data), 32'(qd[0]));
      chk("row", 32'(out_row), 32'(qr[0]));
      chk("col", 32'(out_col), 32'(qc[0]));
      chk("last", 32'(out_last), 32'(qd.size() == 1));
      chk("done_mid", 32'(done), 32'd0);
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (guard % 4 == 1) || (guard % 4 == 0);
        default: out_ready = ($urandom % 2 == 1) || (guard % 4 == 0);
      endcase
      if (out_ready) begin
        if (k < 16) obs[k] = out_data;
        k++;
        void'(qd.pop_front());
        void'(qr.pop_front());
        void'(qc.pop_front());
      end
    end
    chk("stream_timeout", 32'(qd.size()), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    mat_in = '0; start = 1'b0; col_major = 1'b0; out_ready = 1'b0;
    mat_in3 = '0; start3 = 1'b0; col_major3 = 1'b0; out_ready3 = 1'b0;

    tbl[0] = '{1'b0, 0, 8'h11};
    tbl[1] = '{1'b0, 3, 8'h14};
    tbl[2] = '{1'b0, 4, 8'h21};
    tbl[3] = '{1'b0, 15, 8'h44};
    tbl[4] = '{1'b1, 1, 8'h21};
    tbl[5] = '{1'b1, 4, 8'h12};
    tbl[6] = '{1'b1, 7, 8'h42};
    tbl[7] = '{1'b1, 15, 8'h44};

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mat_dir[(r * 4 + c) * 8 +: 8] = {4'(r + 1), 4'(c + 1)};
      end
    end

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_rowcol", 32'({out_row, out_col}), 32'd0);
    chk("rst3_valid", 32'(out_valid3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_stream(mat_dir, 1'b0, 0, 1'b0);
    obs_rm = obs;
    run_stream(mat_dir, 1'b1, 0, 1'b0);
    obs_cm = obs;
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d", i), 32'(tbl[i].cm ? obs_cm[tbl[i].k] : obs_rm[tbl[i].k]),
          32'(tbl[i].exp));
    end

    run_stream(mat_dir, 1'b0, 1, 1'b0);
    run_stream(mat_dir, 1'b1, 1, 1'b1);

    // Abort mid-stream after 5 accepts; reset must clear outputs without a clock edge.
    @(negedge clk);
    mat_in = mat_dir; col_major = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_data", 32'(out_data), 32'h21);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_rowcol", 32'({out_row, out_col}), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    run_stream(mat_dir, 1'b0, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      logic [127:0] m;
      m = {$urandom, $urandom, $urandom, $urandom};
      run_stream(m, 1'($urandom), 2, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // DIM=3: start held through done restarts after exactly one bubble cycle.
    for (int i = 0; i < 9; i++) mat_in3[i * 16 +: 16] = 16'($urandom);
    @(negedge clk);
    col_major3 = 1'b0; start3 = 1'b1; out_ready3 = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        if (pass == 1 && i == 4) start3 = 1'b0;
        chk("d3_valid", 32'(out_valid3), 32'd1);
        chk("d3_data", 32'(out_data3), 32'(mat_in3[i * 16 +: 16]));
        chk("d3_row", 32'(out_row3), 32'(i / 3));
        chk("d3_col", 32'(out_col3), 32'(i % 3));
        chk("d3_last", 32'(out_last3), 32'(i == 8));
      end
      @(negedge clk);
      chk("d3_done", 32'(done3), 32'd1);
      chk("d3_bubble", 32'(out_valid3), 32'd0);
    end
    @(negedge clk);
    chk("d3_idle", 32'(out_valid3), 32'd0);
    chk("d3_done_single", 32'(done3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
